// File: rtl/pulse_stretcher_pkg.sv
// Shared types for the pulse stretcher: FSM state encoding and a small sizing helper.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_stretcher_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 and flags a tick on the last count.
module pulse_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);
    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] r_cnt;

    assign tick = (r_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (restart || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into ON_TICKS-long visible pulses separated by
// GAP_TICKS of forced low, queueing events that arrive while a pulse is in flight.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | nothing in flight, waiting for an accepted event
// ST_ON    | stretchedOut high for ON_TICKS ticks
// ST_GAP   | forced low for GAP_TICKS ticks, then serve queue or go idle
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int TICK_DIV  = 1000,
    parameter int ON_TICKS  = 4,
    parameter int GAP_TICKS = 2,
    parameter int QUEUE_MAX = 15
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           pulseIn,
    input  logic                           clearOverflow,
    output logic                           stretchedOut,
    output logic                           busy,
    output logic [$clog2(QUEUE_MAX+1)-1:0] pendingCount,
    output logic                           overflow
);
    localparam int TC_W = $clog2(max_of(ON_TICKS, GAP_TICKS) + 1);
    localparam int PC_W = $clog2(QUEUE_MAX + 1);

    state_t           r_state;
    state_t           w_next;
    logic [TC_W-1:0]  r_tick_cnt;
    logic [PC_W-1:0]  r_pend;
    logic [PC_W-1:0]  w_pend_next;
    logic             r_out;
    logic             r_ovf;
    logic             w_ovf_set;
    logic             w_tick;
    logic             w_restart;
    logic             w_accept;
    logic             w_phase_end;
    logic             w_pend_zero;
    logic             w_pend_full;

    assign w_accept    = pulseIn & enable;
    assign w_pend_zero = (r_pend == '0);
    assign w_pend_full = (r_pend == PC_W'(QUEUE_MAX));
    assign w_phase_end = w_tick &&
                         (((r_state == ST_ON)  && (r_tick_cnt == TC_W'(ON_TICKS - 1))) ||
                          ((r_state == ST_GAP) && (r_tick_cnt == TC_W'(GAP_TICKS - 1))));

    // Holding the prescaler in restart while idle also gives the restart on ON entry.
    assign w_restart = (w_next != r_state) || (r_state == ST_IDLE);

    pulse_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .restart (w_restart),
        .tick    (w_tick)
    );

    always_comb begin
        w_next      = r_state;
        w_pend_next = r_pend;
        w_ovf_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = ST_ON;
            end
            ST_ON: begin
                if (w_accept) begin
                    if (w_pend_full) w_ovf_set = 1'b1;
                    else             w_pend_next = r_pend + PC_W'(1);
                end
                if (w_phase_end) w_next = ST_GAP;
            end
            ST_GAP: begin
                if (w_phase_end) begin
                    // A same-cycle event is served directly, so the queue is only drained otherwise.
                    w_next = (!w_pend_zero || w_accept) ? ST_ON : ST_IDLE;
                    if (!w_pend_zero && !w_accept) w_pend_next = r_pend - PC_W'(1);
                end else if (w_accept) begin
                    if (w_pend_full) w_ovf_set = 1'b1;
                    else             w_pend_next = r_pend + PC_W'(1);
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= '0;
            r_pend     <= '0;
            r_out      <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pend  <= w_pend_next;
            r_out   <= (w_next == ST_ON);
            if (w_restart)   r_tick_cnt <= '0;
            else if (w_tick) r_tick_cnt <= r_tick_cnt + TC_W'(1);
            if (w_ovf_set)          r_ovf <= 1'b1;
            else if (clearOverflow) r_ovf <= 1'b0;
        end
    end

    assign stretchedOut = r_out;
    assign busy         = (r_state != ST_IDLE);
    assign pendingCount = r_pend;
    assign overflow     = r_ovf;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with TICK_DIV=4, ON_TICKS=3, GAP_TICKS=2, QUEUE_MAX=3.
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       pulseIn;
    logic       clearOverflow;
    logic       stretchedOut;
    logic       busy;
    logic [1:0] pendingCount;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pulse_stretcher #(
        .TICK_DIV  (4),
        .ON_TICKS  (3),
        .GAP_TICKS (2),
        .QUEUE_MAX (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .pulseIn       (pulseIn),
        .clearOverflow (clearOverflow),
        .stretchedOut  (stretchedOut),
        .busy          (busy),
        .pendingCount  (pendingCount),
        .overflow      (overflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Check out/busy/pending for n consecutive cycles, advancing one clock after each.
    task automatic span(input string tag, input int n, input logic eo, input logic eb,
                        input logic [1:0] ep);
        for (int i = 0; i < n; i++) begin
            chk({tag, "/out"},  {7'd0, stretchedOut}, {7'd0, eo});
            chk({tag, "/busy"}, {7'd0, busy},         {7'd0, eb});
            chk({tag, "/pend"}, {6'd0, pendingCount}, {6'd0, ep});
            step();
        end
    endtask

    initial begin
        reset         = 1'b1;
        enable        = 1'b1;
        pulseIn       = 1'b0;
        clearOverflow = 1'b0;
        step();
        step();
        chk("rst/out",  {7'd0, stretchedOut}, 8'd0);
        chk("rst/busy", {7'd0, busy},         8'd0);
        chk("rst/pend", {6'd0, pendingCount}, 8'd0);
        chk("rst/ovf",  {7'd0, overflow},     8'd0);
        reset = 1'b0;
        span("idle0", 5, 1'b0, 1'b0, 2'd0);

        // single event
        pulseIn = 1'b1; step(); pulseIn = 1'b0;
        span("t1_on",   12, 1'b1, 1'b1, 2'd0);
        span("t1_gap",   8, 1'b0, 1'b1, 2'd0);
        span("t1_idle",  3, 1'b0, 1'b0, 2'd0);

        // events at N, N+2, N+4
        pulseIn = 1'b1; step();
        chk("t2_on0", {7'd0, stretchedOut}, 8'd1);
        pulseIn = 1'b0; step();
        pulseIn = 1'b1; step();
        chk("t2_p1", {6'd0, pendingCount}, 8'd1);
        pulseIn = 1'b0; step();
        pulseIn = 1'b1; step();
        pulseIn = 1'b0;
        span("t2_on1",  8, 1'b1, 1'b1, 2'd2);
        span("t2_gap1", 8, 1'b0, 1'b1, 2'd2);
        span("t2_on2", 12, 1'b1, 1'b1, 2'd1);
        span("t2_gap2", 8, 1'b0, 1'b1, 2'd1);
        span("t2_on3", 12, 1'b1, 1'b1, 2'd0);
        span("t2_gap3", 8, 1'b0, 1'b1, 2'd0);
        span("t2_idle", 2, 1'b0, 1'b0, 2'd0);

        // start event plus six back-to-back events during ON -> saturation
        pulseIn = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("t3_pend", {6'd0, pendingCount}, (k - 1 > 3) ? 8'd3 : 8'(k - 1));
            chk("t3_ovf",  {7'd0, overflow},     (k >= 5) ? 8'd1 : 8'd0);
            chk("t3_out",  {7'd0, stretchedOut}, 8'd1);
        end
        pulseIn = 1'b0;
        span("t3_on1",  6, 1'b1, 1'b1, 2'd3);
        span("t3_gap1", 8, 1'b0, 1'b1, 2'd3);
        span("t3_on2", 12, 1'b1, 1'b1, 2'd2);
        span("t3_gap2", 8, 1'b0, 1'b1, 2'd2);
        span("t3_on3", 12, 1'b1, 1'b1, 2'd1);
        span("t3_gap3", 8, 1'b0, 1'b1, 2'd1);
        span("t3_on4", 12, 1'b1, 1'b1, 2'd0);
        span("t3_gap4", 8, 1'b0, 1'b1, 2'd0);
        span("t3_idle", 2, 1'b0, 1'b0, 2'd0);
        chk("t3_ovf_held", {7'd0, overflow}, 8'd1);
        clearOverflow = 1'b1; step(); clearOverflow = 1'b0;
        chk("t3_ovf_clr", {7'd0, overflow}, 8'd0);

        // event in the final GAP cycle with an empty queue
        pulseIn = 1'b1; step(); pulseIn = 1'b0;
        span("t4_on1", 12, 1'b1, 1'b1, 2'd0);
        span("t4_gap1", 7, 1'b0, 1'b1, 2'd0);
        chk("t4_last_gap", {7'd0, busy}, 8'd1);
        pulseIn = 1'b1; step(); pulseIn = 1'b0;
        span("t4_on2", 12, 1'b1, 1'b1, 2'd0);
        span("t4_gap2", 8, 1'b0, 1'b1, 2'd0);
        span("t4_idle", 2, 1'b0, 1'b0, 2'd0);

        // enable low: ignored in IDLE, queued window still served
        enable = 1'b0; pulseIn = 1'b1;
        span("t5_dis", 3, 1'b0, 1'b0, 2'd0);
        enable = 1'b1;
        step();
        step();
        pulseIn = 1'b0; enable = 1'b0;
        span("t5_on1", 11, 1'b1, 1'b1, 2'd1);
        span("t5_gap1", 8, 1'b0, 1'b1, 2'd1);
        pulseIn = 1'b1;
        span("t5_on2", 12, 1'b1, 1'b1, 2'd0);
        span("t5_gap2", 8, 1'b0, 1'b1, 2'd0);
        pulseIn = 1'b0; enable = 1'b1;
        span("t5_idle", 2, 1'b0, 1'b0, 2'd0);

        // asynchronous reset mid-ON with two queued events
        pulseIn = 1'b1; step(); step(); step(); pulseIn = 1'b0;
        chk("t6_pend", {6'd0, pendingCount}, 8'd2);
        chk("t6_out",  {7'd0, stretchedOut}, 8'd1);
        step(); step();
        #2 reset = 1'b1;
        #1;
        chk("t6_async_out",  {7'd0, stretchedOut}, 8'd0);
        chk("t6_async_busy", {7'd0, busy},         8'd0);
        chk("t6_async_pend", {6'd0, pendingCount}, 8'd0);
        chk("t6_async_ovf",  {7'd0, overflow},     8'd0);
        step();
        reset = 1'b0;
        span("t6_quiet", 10, 1'b0, 1'b0, 2'd0);
        pulseIn = 1'b1; step(); pulseIn = 1'b0;
        span("t6_on",  12, 1'b1, 1'b1, 2'd0);
        span("t6_gap",  8, 1'b0, 1'b1, 2'd0);
        span("t6_idle", 2, 1'b0, 1'b0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 The block SHALL provide parameter TICK_DIV, default 1000, clk cycles per tick; legal range 2 or more.
REQ-002 The block SHALL provide parameter ON_TICKS, default 4, ticks for which stretchedOut is high per event; legal range 1 or more.
REQ-003 The block SHALL provide parameter GAP_TICKS, default 2, ticks of forced-low gap after each ON phase; legal range 1 or more.
REQ-004 The block SHALL provide parameter QUEUE_MAX, default 15, saturation value of the pending-event counter.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
- clk  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high.
- enable  input  1  when low, pulseIn is ignored.
- pulseIn  input  1  single-cycle event request, synchronous to clk.
- clearOverflow  input  1  synchronous clear of the overflow flag.
- stretchedOut  output  1  registered, human-visible stretched pulse.
- busy  output  1  high whenever state is not IDLE.
- pendingCount  output  $clog2(QUEUE_MAX+1)  queued, not-yet-served events.
- overflow  output  1  sticky flag: an event was lost at saturation.

Function
REQ-006 The block SHALL implement three states: IDLE, ON, GAP. stretchedOut SHALL be 1 exactly when the state is ON.
REQ-007 The block SHALL qualify an accepted event as pulseIn & enable in the same cycle.
REQ-008 The prescaler SHALL count 0 to TICK_DIV-1 and SHALL restart at 0 on every entry to ON or GAP; a tick occurs in the cycle where it equals TICK_DIV-1.
REQ-009 From IDLE, an accepted event in cycle N SHALL move the block to ON, with stretchedOut high from cycle N+1; that event SHALL NOT increment pendingCount.
REQ-010 The ON state SHALL last exactly ON_TICKS*TICK_DIV cycles, then move to GAP.
REQ-011 The GAP state SHALL last exactly GAP_TICKS*TICK_DIV cycles.
REQ-012 At the end of GAP, the block SHALL move to ON if pendingCount>0 or an event is accepted that cycle; otherwise it SHALL move to IDLE.
REQ-013 On a GAP-to-ON transition, pendingCount SHALL decrement by 1 if it was >0 and no event is accepted that cycle.
REQ-014 If pendingCount>0 and an event is accepted in the same GAP-end cycle, pendingCount SHALL remain unchanged.
REQ-015 If pendingCount=0 and an event is accepted in the GAP-end cycle, that event SHALL be consumed directly and pendingCount SHALL remain 0.
REQ-016 An accepted event during ON, or during GAP other than its final cycle, SHALL increment pendingCount.
REQ-017 At pendingCount=QUEUE_MAX, an accepted event SHALL leave the count unchanged and set overflow to 1 on the next cycle.
REQ-018 overflow SHALL stay set until clearOverflow=1 or reset. If clearOverflow and a new overflow occur in the same cycle, the set SHALL win.
REQ-019 enable=0 SHALL NOT abort an in-progress ON/GAP sequence. Queued events SHALL still be served while enable=0.
REQ-020 Back-to-back pulseIn on consecutive cycles SHALL count as separate events.

Reset
REQ-021 On reset, the block SHALL immediately set the state to IDLE, stretchedOut=0, busy=0, pendingCount=0, overflow=0, prescaler=0, and tick counter=0.
REQ-022 Reset asserted mid-ON or mid-GAP SHALL discard all queued events. After release, the block SHALL take no action until a new accepted event.

Structure
REQ-023 The state encoding constants (IDLE, ON, GAP) SHALL be defined in the shared project package/header; parameter defaults SHALL stay local.
REQ-024 The prescaler SHALL be one sub-module, pulse_tick_gen, with ports clk, reset, restart, and tick.
REQ-025 The ON/GAP tick counter and the pending counter SHALL be sized with $clog2 of their maxima.

Verification (TICK_DIV=4, ON_TICKS=3, GAP_TICKS=2, QUEUE_MAX=3)
REQ-026 Single pulseIn at cycle 10 from IDLE -> stretchedOut high in cycles 11-22 (12 cycles), low in cycles 23-30, busy low from cycle 31, pendingCount stays 0.
REQ-027 Pulses at cycles 10, 12, 14 -> three ON windows of 12 cycles separated by 8-cycle gaps; pendingCount reads 2, then 1, then 0.
REQ-028 Six pulses during the first ON window -> pendingCount saturates at 3, overflow=1; exactly 4 ON windows total; clearOverflow pulse -> overflow=0 next cycle.
REQ-029 pulseIn in the final GAP cycle with pendingCount=0 -> ON entered next cycle, no IDLE cycle, pendingCount stays 0.
REQ-030 enable=0 with pulses in IDLE -> no output. With one queued event, enable dropped mid-ON -> the queued window is still produced.
REQ-031 reset asserted mid-ON with pendingCount=2 -> all outputs 0 asynchronously. After release, no output until a new pulseIn.
